// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  // Special-case results for the 32-bit datapath.
  localparam logic [31:0] DIV0_QUOT = '1;
  localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

  function automatic logic op_is_div(md_op_t op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(md_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(md_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
interface ex_muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            ex_hold;
  logic            done;
  logic            busy;
  logic [XLEN-1:0] res;

  modport master (
    output start, op, a, b, flush,
    input  ex_hold, done, busy, res
  );

  modport slave (
    input  start, op, a, b, flush,
    output ex_hold, done, busy, res
  );
endinterface

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_iter_dp #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   mag_a_i,
  input  logic [XLEN-1:0]   mag_b_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quot_o,
  output logic [XLEN-1:0]   rem_o
);

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  // Divide: acc low half shifts the dividend out and the quotient in.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              div_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    acc_d     = acc_q;
    rem_d     = rem_q;
    if (div_q) begin
      // A borrow out of the top bit means the trial subtract failed: restore.
      if (div_diff[XLEN]) begin
        rem_d               = div_shift[XLEN-1:0];
        acc_d[XLEN-1:0]     = {acc_q[XLEN-2:0], 1'b0};
      end else begin
        rem_d               = div_diff[XLEN-1:0];
        acc_d[XLEN-1:0]     = {acc_q[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      opb_q <= '0;
      rem_q <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= {{XLEN{1'b0}}, mag_a_i};
      opb_q <= mag_b_i;
      rem_q <= '0;
      div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end

  assign prod_o = acc_q;
  assign quot_o = acc_q[XLEN-1:0];
  assign rem_o  = rem_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Sequencer for the shared iterative RV32M unit: FSM, sign handling, special cases, hold/done.
module ex_muldiv_ctrl
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ex_muldiv_ctrl_if.slave   md_io
);

  state_t            state_q;
  md_op_t            op_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   res_q;
  logic              done_q;
  logic              busy_q;

  md_op_t            op_in;
  logic              accept;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div0, ovf;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign op_in  = md_op_t'(md_io.op);
  assign accept = (state_q == IDLE) && md_io.start && !md_io.flush;
  assign neg_a  = op_a_signed(op_in) && md_io.a[XLEN-1];
  assign neg_b  = op_b_signed(op_in) && md_io.b[XLEN-1];
  assign mag_a  = neg_a ? -md_io.a : md_io.a;
  assign mag_b  = neg_b ? -md_io.b : md_io.b;
  assign div0   = op_is_div(op_in) && (md_io.b == '0);
  assign ovf    = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (md_io.a == {1'b1, {(XLEN-1){1'b0}}}) && (md_io.b == '1);

  // op[1] separates REM/REMU from DIV/DIVU among the divide codes.
  always_comb begin
    special_res = '0;
    if (div0) begin
      special_res = op_in[1] ? md_io.a : XLEN'(DIV0_QUOT);
    end else if (ovf) begin
      special_res = op_in[1] ? '0 : XLEN'(OVF_QUOT);
    end
  end

  muldiv_iter_dp #(
    .XLEN (XLEN)
  ) u_dp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (accept),
    .step_i   (state_q == CALC),
    .is_div_i (op_is_div(op_in)),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .prod_o   (prod),
    .quot_o   (quot),
    .rem_o    (rem)
  );

  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -quot : quot;
  assign rem_fix  = neg_q ? -rem  : rem;

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quot_fix;
      OP_REM, OP_REMU:               fix_res = rem_fix;
      default:                       fix_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= op_in;
            // Remainder takes the dividend's sign; everything else the XOR.
            neg_q  <= op_in[2] && op_in[1] ? neg_a : (neg_a ^ neg_b);
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (div0 || ovf) begin
              res_q   <= special_res;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (md_io.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          if (md_io.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            res_q   <= fix_res;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign md_io.ex_hold = accept || (state_q == CALC) || (state_q == FIX);
  assign md_io.done    = done_q;
  assign md_io.busy    = busy_q;
  assign md_io.res     = res_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: expected results queued at issue, checked on done.
module tb_ex_muldiv_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   done_cnt;
  int   hold_cnt;
  int   last_done_cyc;
  int   prev_done_cyc;
  logic [31:0] last_res;

  logic [31:0] sb_res[$];
  int          sb_lat[$];
  int          sb_cyc[$];
  string       sb_tag[$];

  ex_muldiv_ctrl_if #(.XLEN(32)) bus ();

  ex_muldiv_ctrl #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .md_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Monitor: one pop per done pulse; operands are sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ex_hold) hold_cnt++;
      if (bus.done) begin
        done_cnt++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        if (sb_res.size() == 0) begin
          check_eq("spurious_done", bus.done, 1'b0);
        end else begin
          string t;
          t = sb_tag.pop_front();
          check_eq({t, "_res"}, bus.res, sb_res.pop_front());
          check_eq({t, "_lat"}, cyc - sb_cyc.pop_front(), sb_lat.pop_front());
          check_eq({t, "_hold_at_done"}, bus.ex_hold, 1'b0);
          check_eq({t, "_busy_at_done"}, bus.busy, 1'b1);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after done (or after the tail).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold, input bit tail);
    int  n0, h0;
    bit  seen;
    n0 = done_cnt;
    h0 = hold_cnt;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb_res.push_back(exp);
    sb_lat.push_back(lat);
    sb_cyc.push_back(cyc);
    sb_tag.push_back(tag);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      if (done_cnt != n0) seen = 1'b1;
    end
    bus.start = 1'b0;
    check_eq({tag, "_done_seen"}, seen, 1'b1);
    if (!seen) begin
      sb_res.delete(); sb_lat.delete(); sb_cyc.delete(); sb_tag.delete();
    end
    last_res = exp;
    if (tail) begin
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, "_one_done"}, done_cnt - n0, 1);
      check_eq({tag, "_hold_cycles"}, hold_cnt - h0, lat);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int n0;
    n_checks = 0; n_fail = 0; done_cnt = 0; hold_cnt = 0;
    last_done_cyc = 0; prev_done_cyc = 0; last_res = '0; cyc = 0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_res", bus.res, 32'd0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_hold", bus.ex_hold, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",  3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 1);
    run_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 1);
    run_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 1);
    run_op("mulhsu_min",3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34, 0, 1);
    run_op("div_m20_6", 3'd4, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34, 1, 1);
    run_op("rem_m20_6", 3'd6, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 34, 0, 1);
    run_op("divu_20_6", 3'd5, 32'd20, 32'd6, 32'd3, 34, 0, 1);
    run_op("divu_by0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1);
    run_op("rem_by0",   3'd6, 32'd5, 32'd0, 32'd5, 1, 1, 1);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1);

    // Flush at counter 10: cycle 0 accept, cycle 1 is counter 0.
    n0 = done_cnt;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd123; bus.b = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check_eq("flush_hold_during", bus.ex_hold, 1'b1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy_after", bus.busy, 1'b0);
    check_eq("flush_hold_after", bus.ex_hold, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("flush_no_done", done_cnt - n0, 0);
    check_eq("flush_res_kept", bus.res, last_res);

    // start together with flush in IDLE is not accepted.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.a = 32'd9; bus.b = 32'd0;
    @(negedge clk);
    check_eq("idle_flush_hold", bus.ex_hold, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    run_op("after_flush", 3'd7, 32'd100, 32'd7, 32'd2, 34, 0, 1);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_md(rop, ra, rb),
             ref_lat(rop, ra, rb), 0, 1);
    end

    run_op("b2b_first",  3'd1, 32'h1234_5678, 32'h9ABC_DEF0,
           ref_md(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 34, 0, 0);
    run_op("b2b_second", 3'd7, 32'hDEAD_BEEF, 32'd1000,
           ref_md(3'd7, 32'hDEAD_BEEF, 32'd1000), 34, 0, 1);
    check_eq("b2b_gap", last_done_cyc - prev_done_cyc, 35);

    // Asynchronous reset in the middle of CALC, away from the clock edge.
    n0 = done_cnt;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd11; bus.b = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_res", bus.res, 32'd0);
    check_eq("arst_busy", bus.busy, 1'b0);
    check_eq("arst_hold", bus.ex_hold, 1'b0);
    check_eq("arst_done", bus.done, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("arst_no_done", done_cnt - n0, 0);
    run_op("after_arst", 3'd0, 32'd11, 32'd13, 32'd143, 34, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Sequencer for a shared iterative multiply/divide unit (RV32M) attached to the execute stage.
- Accepts one M-extension op from the ID/EX register and runs a radix-2 shift-add multiply or a restoring divide over XLEN cycles.
- Raises a pipeline hold, alongside the memory hold, until the result is ready, then presents the result for EX/MEM capture.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- start  in  1  ID_EX holds a valid M-op; sampled only in IDLE.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  XLEN  forwarded rs1 operand.
- b  in  XLEN  forwarded rs2 operand.
- flush  in  1  branch/jump squash; aborts the op in flight.
- ex_hold  out  1  stall request to the IF/ID/EX registers.
- done  out  1  one-cycle pulse; res is valid this cycle.
- busy  out  1  FSM is not IDLE.
- res  out  XLEN  result register.

Behaviour:
- Reset (Rst=0, async): state=IDLE; ex_hold=0, done=0, busy=0, res=0; counter and accumulators cleared.
- ex_hold is combinational: (state==IDLE && start && !flush) || state==CALC || state==FIX. It is 0 in DONE, so the pipeline advances in the same cycle done=1.
- IDLE: on start && !flush, latch the operand magnitudes (signed per op), the sign flags and op; counter=0.
  - Div-by-zero or signed overflow (-2^31 / -1) goes directly to DONE (latency 1).
  - Otherwise go to CALC.
- CALC: one iteration per cycle for XLEN cycles (counter 0..XLEN-1).
  - Multiply: 2*XLEN-bit product accumulator, shift-add on the unsigned magnitudes.
  - Divide: restoring; partial remainder XLEN+1 bits.
  - At counter==XLEN-1, go to FIX.
- FIX: apply the sign correction (two's complement negate), select the low or high word or the quotient/remainder, write res, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - The start present in this cycle is the same instruction and is ignored.
  - The next op may start in the following cycle.
- Normal latency: start seen in cycle 0, done in cycle XLEN+2 (34 for XLEN=32). Special cases: done in cycle 1.
- Special results:
  - DIV/DIVU by 0: quotient = all ones.
  - REM/REMU by 0: remainder = a.
  - Signed overflow: DIV = 0x80000000, REM = 0.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- flush in any non-IDLE state: next cycle is IDLE, no done, res unchanged, ex_hold drops the cycle after flush. flush with start in IDLE: not accepted.
- Operand changes on a/b after acceptance are ignored; only the latched copies are used.
- res holds its last value until the next FIX/special-case write.

Decomposition:
- Package ex_muldiv_pkg:
  - typedef enum state_t {IDLE, CALC, FIX, DONE}.
  - typedef enum md_op_t for the 8 funct3 codes.
  - Constants DIV0_QUOT='1 and OVF_QUOT=32'h8000_0000.
- One sub-module, muldiv_iter_dp: the shift/add/subtract step datapath (accumulator registers plus one-iteration combinational step). ex_muldiv_ctrl keeps the FSM, counter, sign handling and hold/done generation.

Test Plan:
- MUL: a=7, b=-3 (0xFFFFFFFD), start 1 cycle -> ex_hold high cycles 0-33; done in cycle 34; res=0xFFFFFFEB.
- MULH/MULHU/MULHSU: a=b=0x80000000 -> MULH res=0x40000000; MULHU res=0x40000000; MULHSU res=0xC0000000.
- DIV: a=-20, b=6 -> res=0xFFFFFFFD (-3). REM, same operands -> res=0xFFFFFFFE (-2). DIVU: a=20, b=6 -> res=3.
- Div by zero: DIVU a=5, b=0 -> done in cycle 1, res=0xFFFFFFFF. REM a=5, b=0 -> res=5. Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> res=0x80000000 in cycle 1.
- flush asserted at CALC counter=10 -> IDLE next cycle, done never pulses, res keeps its prior value. A new start two cycles later completes normally.
- Async reset: drop Rst mid-CALC, away from a clock edge -> outputs zero immediately. start held high through DONE -> exactly one done per instruction. Back-to-back ops give two done pulses 35 cycles apart.
